// File: rtl/seven_segment_pkg.sv
// Shared 7-segment pattern table (active-low {g..a}) and the reverse lookup used
// by the scan decoder; the drive-side encoder indexes the same table.
package seven_segment_pkg;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Entry i is the lit pattern for hex digit i; element 15 is listed first.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110,
        7'b0000011, 7'b0001000, 7'b0010000, 7'b0000000,
        7'b1111000, 7'b0000010, 7'b0010010, 7'b0011001,
        7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
    };

    // Returns {hit, is_blank, value[3:0]}.
    function automatic logic [5:0] seg_decode(input logic [6:0] p);
        logic [5:0] r;
        r = {1'b0, (p == SEG_BLANK), 4'h0};
        for (int i = 0; i < 16; i++) begin
            if (p == SEG_TABLE[i]) r = {2'b10, 4'(i)};
        end
        return r;
    endfunction

endpackage

// File: rtl/seven_segment_pattern_decode.sv
// Combinational reverse lookup of an active-low segment pattern to its hex value.
module seven_segment_pattern_decode
    import seven_segment_pkg::*;
(
    input  logic [6:0] pat,
    output logic       hit,
    output logic       is_blank,
    output logic [3:0] value
);

    always_comb begin
        {hit, is_blank, value} = seg_decode(pat);
    end

endmodule

// File: rtl/seven_segment_scan_decoder.sv
// Snoops a multiplexed 7-segment bus, waits for a stable one-hot window per digit
// and commits the decoded hex value into that digit's slot.
module seven_segment_scan_decoder
    import seven_segment_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int STABLE_CYCLES  = 4,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [6:0]              seg_in,
    input  logic [NUM_DIGITS-1:0]   an_in,
    output logic [4*NUM_DIGITS-1:0] digits_out,
    output logic [NUM_DIGITS-1:0]   digit_valid,
    output logic                    update_pulse,
    output logic                    pattern_err,
    output logic [2:0]              err_digit
);

    localparam int         SW     = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [7:0] STABLE = 8'(STABLE_CYCLES);

    logic [6:0]            seg_s1, seg_s2;
    logic [NUM_DIGITS-1:0] an_s1, an_s2;
    logic [NUM_DIGITS+6:0] prev_q;
    logic [7:0]            cnt;
    logic                  commit_q;
    logic [SW-1:0]         commit_slot;
    logic [6:0]            commit_pat;
    logic [NUM_DIGITS-1:0][3:0] dig_q;

    logic [6:0]            seg_norm;
    logic [NUM_DIGITS-1:0] an_norm;
    logic [NUM_DIGITS+6:0] samp;
    logic                  onehot;
    logic [SW-1:0]         slot;
    logic [7:0]            cnt_nxt;
    logic                  hit, is_blank;
    logic [3:0]            value;

    always_comb begin
        seg_norm = SEG_ACTIVE_LOW ? seg_s2 : ~seg_s2;
        an_norm  = AN_ACTIVE_LOW ? ~an_s2 : an_s2;
        samp     = {an_norm, seg_norm};
        onehot   = (an_norm != '0) && ((an_norm & (an_norm - 1'b1)) == '0);
        slot     = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (an_norm[i]) slot = SW'(i);
        end
        // Blanking/ghost intervals (zero- or multi-hot) discard the window.
        if (!onehot)            cnt_nxt = 8'd0;
        else if (samp != prev_q) cnt_nxt = 8'd1;
        else if (cnt >= STABLE)  cnt_nxt = STABLE;
        else                     cnt_nxt = cnt + 8'd1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            seg_s1      <= '0;
            seg_s2      <= '0;
            an_s1       <= '0;
            an_s2       <= '0;
            prev_q      <= '0;
            cnt         <= '0;
            commit_q    <= 1'b0;
            commit_slot <= '0;
            commit_pat  <= '0;
        end else begin
            seg_s1      <= seg_in;
            seg_s2      <= seg_s1;
            an_s1       <= an_in;
            an_s2       <= an_s1;
            prev_q      <= samp;
            cnt         <= cnt_nxt;
            // Fires only on the edge the count reaches the threshold, so a held bus commits once.
            commit_q    <= (cnt_nxt == STABLE) && (cnt != STABLE);
            commit_slot <= slot;
            commit_pat  <= seg_norm;
        end
    end

    seven_segment_pattern_decode u_dec (
        .pat      (commit_pat),
        .hit      (hit),
        .is_blank (is_blank),
        .value    (value)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dig_q        <= '0;
            digit_valid  <= '0;
            update_pulse <= 1'b0;
            pattern_err  <= 1'b0;
            err_digit    <= '0;
        end else begin
            update_pulse <= commit_q;
            pattern_err  <= 1'b0;
            if (commit_q) begin
                if (hit) begin
                    dig_q[commit_slot]       <= value;
                    digit_valid[commit_slot] <= 1'b1;
                end else begin
                    digit_valid[commit_slot] <= 1'b0;
                    if (!is_blank) begin
                        pattern_err <= 1'b1;
                        err_digit   <= 3'(commit_slot);
                    end
                end
            end
        end
    end

    assign digits_out = dig_q;

endmodule
